// File: rtl/generic_lscan_tracker.sv
// generic_lscan_tracker: passive observer for the generic load/store bus.
// It follows each read or write burst through its data and response phases
// and counts beats, wait cycles and errors. A burst that stalls for too long
// is aborted. Each finished transaction is queued as one packed record in a
// first-word-fall-through FIFO.
// Optional feature: define GENERIC_LSCAN_TRACKER_CSUM_EN to keep a per-transaction
// XOR checksum of the accepted beat data, stored in the record above addr.
module generic_lscan_tracker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 256,
`ifdef GENERIC_LSCAN_TRACKER_CSUM_EN
  localparam int RECW   = 2*WIDTH + 51
`else
  localparam int RECW   = WIDTH + 51
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CS,
  input  logic             CMD,
  input  logic [7:0]       PRIORITY,
  input  logic [7:0]       BURST,
  input  logic [7:0]       SIZE,
  input  logic [WIDTH-1:0] ADDR,
  input  logic [WIDTH-1:0] wDATA,
  input  logic [WIDTH-1:0] rDATA,
  input  logic             STATUS,
  input  logic             REC_READY,
  output logic             REC_VALID,
  output logic [RECW-1:0]  REC_DATA,
  output logic             BUSY,
  output logic [7:0]       DROP_CNT
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WDATA = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RDATA = 3'd3;
  localparam logic [2:0] S_RRESP = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]       state;
  logic             cmd_q;
  logic [7:0]       prio_q;
  logic [7:0]       burst_q;
  logic [7:0]       bytes_q;
  logic [7:0]       beats_q;
  logic [15:0]      waits_q;
  logic [15:0]      run_q;
  logic [1:0]       err_q;
  logic [WIDTH-1:0] addr_q;
  logic [RECW-1:0]  rec_word;

  logic             in_data;
  logic             in_resp;
  logic             burst_left;
  logic             timeout_hit;
  logic [16:0]      run_nx;

  logic             size_unused;
  assign size_unused = ^SIZE[7:3];

  assign in_data     = (state == S_WDATA) || (state == S_RDATA);
  assign in_resp     = (state == S_WRESP) || (state == S_RRESP);
  assign burst_left  = (beats_q != burst_q);
  assign run_nx      = {1'b0, run_q} + 17'd1;
  assign timeout_hit = (run_nx >= TO_LIM);
  assign BUSY        = (state != S_IDLE);

  // Burst phase sequencing; CS is only looked at while idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (CS) state <= CMD ? S_WDATA : S_RDATA;
        S_WDATA, S_RDATA: begin
          if (!burst_left)      state <= S_DONE;
          else if (STATUS)      state <= (state == S_WDATA) ? S_WRESP : S_RRESP;
          else if (timeout_hit) state <= S_DONE;
        end
        S_WRESP: state <= S_WDATA;
        S_RRESP: state <= S_RDATA;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Transaction fields and beat/wait/error accounting; cleared whenever idle.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE) begin
      beats_q <= 8'd0;
      waits_q <= 16'd0;
      run_q   <= 16'd0;
      err_q   <= 2'b00;
      if (CS) begin
        cmd_q   <= CMD;
        prio_q  <= PRIORITY;
        burst_q <= BURST;
        bytes_q <= 8'd1 << SIZE[2:0];
        addr_q  <= ADDR;
      end
    end else if (in_data && burst_left) begin
      if (STATUS) begin
        beats_q <= beats_q + 8'd1;
      end else begin
        waits_q <= sat_inc16(waits_q);
        run_q   <= run_nx[15:0];
        if (timeout_hit) err_q[1] <= 1'b1;
      end
    end else if (in_resp) begin
      run_q <= 16'd0;
      if (!STATUS) err_q[0] <= 1'b1;
    end
  end

`ifdef GENERIC_LSCAN_TRACKER_CSUM_EN
  logic [WIDTH-1:0] csum_q;

  // Write data folds in on beat acceptance, read data on the response cycle.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE)
      csum_q <= '0;
    else if ((state == S_WDATA) && burst_left && STATUS)
      csum_q <= csum_q ^ wDATA;
    else if (state == S_RRESP)
      csum_q <= csum_q ^ rDATA;
  end

  assign rec_word = {csum_q, addr_q, waits_q, bytes_q, beats_q, burst_q, prio_q, err_q, cmd_q};
`else
  logic data_unused;
  assign data_unused = ^{wDATA, rDATA};

  assign rec_word = {addr_q, waits_q, bytes_q, beats_q, burst_q, prio_q, err_q, cmd_q};
`endif

  logic [RECW-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            do_write;
  logic            drop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = (state == S_DONE);
  assign pop        = !fifo_empty && REC_READY;
  assign do_write   = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  assign REC_VALID  = !fifo_empty;
  assign REC_DATA   = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

  // FIFO pointers and the saturating drop counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      DROP_CNT <= 8'd0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (drop)     DROP_CNT <= sat_inc8(DROP_CNT);
    end
  end

  // Record storage; content is only meaningful between the pointers.
  always_ff @(posedge CLK) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= rec_word;
  end

endmodule

// File: tb/tb_generic_lscan_tracker.sv
// Randomized self-checking bench for generic_lscan_tracker with a
// transaction-level reference model and a record scoreboard.
module tb_generic_lscan_tracker;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int TO = 16;
`ifdef GENERIC_LSCAN_TRACKER_CSUM_EN
  localparam int RECW = 2*W + 51;
`else
  localparam int RECW = W + 51;
`endif

  logic            clk = 1'b0;
  logic            RST, CS, CMD, STATUS, REC_READY;
  logic [7:0]      PRIORITY, BURST, SIZE;
  logic [W-1:0]    ADDR, wDATA, rDATA;
  logic            REC_VALID, BUSY;
  logic [RECW-1:0] REC_DATA;
  logic [7:0]      DROP_CNT;

  always #5 clk = ~clk;

  generic_lscan_tracker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST(RST), .CS(CS), .CMD(CMD), .PRIORITY(PRIORITY),
    .BURST(BURST), .SIZE(SIZE), .ADDR(ADDR), .wDATA(wDATA), .rDATA(rDATA),
    .STATUS(STATUS), .REC_READY(REC_READY), .REC_VALID(REC_VALID),
    .REC_DATA(REC_DATA), .BUSY(BUSY), .DROP_CNT(DROP_CNT)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [RECW-1:0] q[$];
  int              drop_m = 0;
  bit              exp_busy = 0;
  bit              drv_push = 0;
  logic [RECW-1:0] drv_rec;
  bit              mon_en = 0;
  int              cyc = 0;
  int              last_cs = 0;
  int              last_rise = 0;
  bit              prev_valid = 0;
  logic [RECW-1:0] last_pop = '0;
  int              rdy_mode = 1;

  int              w_s [16];
  bit              r_s [16];
  logic [W-1:0]    d_s [16];
  bit              dfix = 0;

  function automatic logic [RECW-1:0] pack(input bit c, input logic [1:0] e,
      input logic [7:0] pr, input logic [7:0] bu, input logic [7:0] be,
      input logic [7:0] by, input logic [15:0] wt, input logic [W-1:0] ad,
      input logic [W-1:0] csum_unused_if_off);
    logic [RECW-1:0] r;
    r = '0;
    r[0]        = c;
    r[2:1]      = e;
    r[10:3]     = pr;
    r[18:11]    = bu;
    r[26:19]    = be;
    r[34:27]    = by;
    r[50:35]    = wt;
    r[W+50:51]  = ad;
`ifdef GENERIC_LSCAN_TRACKER_CSUM_EN
    r[2*W+50:W+51] = csum_unused_if_off;
`endif
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       REC_READY = 1'b1;
      2:       REC_READY = 1'b0;
      default: REC_READY = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Scoreboard: compare outputs, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check_val("rec_valid", REC_VALID, q.size() != 0);
      check_val("busy", BUSY, exp_busy);
      check_val("drop_cnt", DROP_CNT, drop_m);
      if (REC_VALID && !prev_valid) last_rise = cyc;
      prev_valid = REC_VALID;
      if (q.size() != 0) check_val("rec_data", REC_DATA, q[0]);
      if (RST) begin
        q.delete();
        drop_m = 0;
      end else begin
        if (q.size() != 0 && REC_READY) begin
          last_pop = REC_DATA;
          void'(q.pop_front());
        end
        if (drv_push) begin
          if (q.size() == D) drop_m = (drop_m < 255) ? drop_m + 1 : 255;
          else q.push_back(drv_rec);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    CS       = 1'($urandom);
    CMD      = 1'($urandom);
    PRIORITY = 8'($urandom);
    BURST    = 8'($urandom);
    SIZE     = 8'($urandom);
    ADDR     = $urandom;
    wDATA    = $urandom;
    rDATA    = $urandom;
    STATUS   = 1'($urandom);
  endtask

  task automatic set_sched(input int wv);
    for (int i = 0; i < 16; i++) begin
      w_s[i] = wv;
      r_s[i] = 1'b1;
      d_s[i] = '0;
    end
    dfix = 0;
  endtask

  task automatic run_txn(input bit c, input logic [7:0] pr, input logic [7:0] bu,
                         input logic [7:0] sz, input logic [W-1:0] ad);
    logic [7:0]   beats;
    logic [15:0]  waits;
    logic [1:0]   err;
    logic [W-1:0] cs;
    int           run;
    bit           ab;
    beats = 0; waits = 0; err = 0; cs = 0; ab = 0;
    noise();
    CS = 1'b1; CMD = c; PRIORITY = pr; BURST = bu; SIZE = sz; ADDR = ad;
    tick();
    last_cs  = cyc;
    exp_busy = 1;
    for (int i = 0; i < int'(bu); i++) begin
      run = 0;
      for (int k = 0; k < w_s[i]; k++) begin
        noise(); STATUS = 1'b0;
        tick();
        waits++; run++;
        if (run == TO) begin
          err[1] = 1'b1;
          ab = 1;
          break;
        end
      end
      if (ab) break;
      noise(); STATUS = 1'b1;
      if (dfix) wDATA = d_s[i];
      if (c) cs ^= wDATA;
      tick();
      beats++;
      noise(); STATUS = r_s[i];
      if (dfix) rDATA = d_s[i];
      if (!c) cs ^= rDATA;
      if (!r_s[i]) err[0] = 1'b1;
      tick();
    end
    if (!ab) begin
      noise();
      tick();
    end
    noise();
    drv_rec  = pack(c, err, pr, bu, beats, 8'd1 << sz[2:0], waits, ad, cs);
    drv_push = 1;
    tick();
    drv_push = 0;
    exp_busy = 0;
    CS = 1'b0;
  endtask

  initial begin
    RST = 1'b1; CS = 1'b0; CMD = 1'b0; PRIORITY = 0; BURST = 0; SIZE = 0;
    ADDR = 0; wDATA = 0; rDATA = 0; STATUS = 0; REC_READY = 1'b1;
    set_sched(0);
    repeat (3) tick();
    check_val("rst_rec_valid", REC_VALID, 0);
    check_val("rst_rec_data", REC_DATA, 0);
    check_val("rst_busy", BUSY, 0);
    check_val("rst_drop_cnt", DROP_CNT, 0);
    mon_en = 1;
    tick();
    RST = 1'b0;
    tick();

    // write burst of 4, no stalls
    rdy_mode = 1;
    set_sched(0);
    run_txn(1'b1, 8'h11, 8'd4, 8'd2, 32'h0000_1000);
    repeat (3) tick();
    check_val("t1_latency", last_rise - last_cs + 1, 11);
    check_val("t1_cmd", last_pop[0], 1);
    check_val("t1_err", last_pop[2:1], 0);
    check_val("t1_beats", last_pop[26:19], 4);
    check_val("t1_bytes", last_pop[34:27], 4);
    check_val("t1_waits", last_pop[50:35], 0);
    check_val("t1_addr", last_pop[W+50:51], 32'h0000_1000);

    // read burst of 2 with 3 initial waits
    set_sched(0);
    w_s[0] = 3; dfix = 1;
    d_s[0] = 32'hA5A5_A5A5; d_s[1] = 32'h0F0F_0F0F;
    run_txn(1'b0, 8'h22, 8'd2, 8'd2, 32'h0000_2000);
    repeat (3) tick();
    check_val("t2_waits", last_pop[50:35], 3);
    check_val("t2_beats", last_pop[26:19], 2);
    check_val("t2_err", last_pop[2:1], 0);
`ifdef GENERIC_LSCAN_TRACKER_CSUM_EN
    check_val("t2_csum", last_pop[2*W+50:W+51], 32'hAAAA_AAAA);
`endif

    // read burst of 3, second response fails
    set_sched(0);
    r_s[1] = 1'b0;
    run_txn(1'b0, 8'h33, 8'd3, 8'd0, 32'h0000_3000);
    repeat (3) tick();
    check_val("t3_err", last_pop[2:1], 2'b01);
    check_val("t3_beats", last_pop[26:19], 3);

    // write burst of 5 stalling after beat 1
    set_sched(0);
    w_s[1] = 100;
    run_txn(1'b1, 8'h44, 8'd5, 8'd3, 32'h0000_4000);
    check_val("t4_busy_after_done", BUSY, 0);
    repeat (3) tick();
    check_val("t4_err", last_pop[2:1], 2'b10);
    check_val("t4_beats", last_pop[26:19], 1);
    check_val("t4_waits", last_pop[50:35], 16);

    // ten empty bursts into a blocked FIFO
    rdy_mode = 2;
    tick();
    set_sched(0);
    for (int i = 0; i < 10; i++) run_txn(1'b0, 8'(i), 8'd0, 8'd0, 32'(i));
    tick();
    check_val("t5_drop_cnt", DROP_CNT, 2);
    check_val("t5_valid_held", REC_VALID, 1);
    check_val("t5_head_addr", REC_DATA[W+50:51], 0);
    rdy_mode = 1;
    repeat (12) tick();
    check_val("t5_drained", REC_VALID, 0);
    check_val("t5_last_addr", last_pop[W+50:51], 7);

    // reset during beat 2 of a write burst of 4
    noise(); CS = 1'b1; CMD = 1'b1; BURST = 8'd4;
    tick();
    exp_busy = 1;
    noise(); STATUS = 1'b1; tick();
    noise(); STATUS = 1'b1; tick();
    noise(); STATUS = 1'b1; RST = 1'b1;
    tick();
    exp_busy = 0;
    RST = 1'b0; CS = 1'b0;
    check_val("t6_busy", BUSY, 0);
    check_val("t6_rec_valid", REC_VALID, 0);
    check_val("t6_drop_cnt", DROP_CNT, 0);
    repeat (20) begin
      noise(); CS = 1'b0;
      tick();
    end
    check_val("t6_no_record", REC_VALID, 0);

    // randomized traffic with random consumer back-pressure
    rdy_mode = 0;
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 16; i++) begin
        w_s[i] = ($urandom_range(0, 19) == 0) ? 20 : int'($urandom_range(0, 3));
        r_s[i] = ($urandom_range(0, 7) != 0);
      end
      dfix = 0;
      run_txn(1'($urandom), 8'($urandom), 8'($urandom_range(0, 6)), 8'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) begin
        noise(); CS = 1'b0;
        tick();
      end
    end
    rdy_mode = 1;
    repeat (12) tick();
    check_val("final_drained", REC_VALID, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
